// File: rtl/gray_sequencer_if.sv
// Bundles the frame-store read port, the converter port and the downstream stream.
// The sequencer uses the master side; the surrounding blocks use the slave side.
interface gray_sequencer_if #(
   parameter int ADDR_W = 20
);
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic [23:0]       rd_data;
   logic              rd_ack;

   logic [3:0][23:0]  in_pixel_buffer;
   logic              gray_en;
   logic [3:0][7:0]   gray_pixel;
   logic              gray_done;

   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_data;
   logic              out_eol;
   logic              out_eof;

   modport master (
      output rd_req, rd_addr,
      input  rd_data, rd_ack,
      output in_pixel_buffer, gray_en,
      input  gray_pixel, gray_done,
      output out_valid, out_data, out_eol, out_eof,
      input  out_ready
   );

   modport slave (
      input  rd_req, rd_addr,
      output rd_data, rd_ack,
      input  in_pixel_buffer, gray_en,
      output gray_pixel, gray_done,
      input  out_valid, out_data, out_eol, out_eof,
      output out_ready
   );
endinterface

// File: rtl/gray_sequencer.sv
// Frame sequencer for the grayscale converter: fetches four RGB pixels, kicks the
// converter, captures the packed result and streams it with row/frame flags.
//
//   state       | meaning
//   ------------+-----------------------------------------------
//   S_IDLE      | waiting for start
//   S_FETCH     | reading pixels into slots 3..0
//   S_GRAY_GO   | one-cycle converter start
//   S_GRAY_WAIT | waiting for the converter result strobe
//   S_EMIT      | presenting the packed gray word downstream
//   S_DONE      | one-cycle frame_done, then back to idle
module gray_sequencer #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int ADDR_W     = 20
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               start,
   gray_sequencer_if.master   bus,
   output logic               busy,
   output logic               frame_done
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_FETCH     = 3'd1;
   localparam logic [2:0] S_GRAY_GO   = 3'd2;
   localparam logic [2:0] S_GRAY_WAIT = 3'd3;
   localparam logic [2:0] S_EMIT      = 3'd4;
   localparam logic [2:0] S_DONE      = 3'd5;

   // One extra index bit: after the last fetch the index equals the pixel count,
   // which may not fit in ADDR_W.
   localparam int IDX_W = ADDR_W + 1;
   localparam int COL_W = $clog2(IMG_WIDTH);

   localparam logic [IDX_W-1:0] NPIX     = IDX_W'(IMG_WIDTH * IMG_HEIGHT);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

   logic [2:0]       state;
   logic [1:0]       slot;
   logic [IDX_W-1:0] idx;
   logic [COL_W-1:0] col;

   assign bus.rd_req    = (state == S_FETCH);
   assign bus.gray_en   = (state == S_GRAY_GO);
   assign bus.out_valid = (state == S_EMIT);
   assign busy          = (state != S_IDLE);
   assign frame_done    = (state == S_DONE);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state               <= S_IDLE;
         slot                <= '0;
         idx                 <= '0;
         col                 <= '0;
         bus.rd_addr         <= '0;
         bus.in_pixel_buffer <= '0;
         bus.out_data        <= '0;
         bus.out_eol         <= 1'b0;
         bus.out_eof         <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  slot        <= '0;
                  idx         <= '0;
                  col         <= '0;
                  bus.rd_addr <= '0;
                  state       <= S_FETCH;
               end
            end

            S_FETCH: begin
               if (bus.rd_ack) begin
                  bus.in_pixel_buffer[~slot] <= bus.rd_data;
                  idx  <= idx + IDX_W'(1);
                  col  <= (col == COL_LAST) ? '0 : col + COL_W'(1);
                  slot <= slot + 2'd1;
                  // rd_addr stays on the last pixel of the word so it never
                  // points past the end of the frame.
                  if (slot == 2'd3) begin
                     state <= S_GRAY_GO;
                  end else begin
                     bus.rd_addr <= bus.rd_addr + ADDR_W'(1);
                  end
               end
            end

            S_GRAY_GO: begin
               state <= S_GRAY_WAIT;
            end

            S_GRAY_WAIT: begin
               if (bus.gray_done) begin
                  bus.out_data <= bus.gray_pixel;
                  bus.out_eol  <= (col == '0);
                  bus.out_eof  <= (idx == NPIX);
                  state        <= S_EMIT;
               end
            end

            S_EMIT: begin
               if (bus.out_ready) begin
                  if (bus.out_eof) begin
                     state <= S_DONE;
                  end else begin
                     slot        <= '0;
                     bus.rd_addr <= bus.rd_addr + ADDR_W'(1);
                     state       <= S_FETCH;
                  end
               end
            end

            S_DONE: begin
               idx         <= '0;
               col         <= '0;
               bus.rd_addr <= '0;
               state       <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gray_sequencer.sv
// Directed bench for gray_sequencer on an 8x2 frame with a frame-store responder,
// a behavioural converter and an output monitor.
module tb_gray_sequencer;
   localparam int W    = 8;
   localparam int H    = 2;
   localparam int AW   = 4;
   localparam int NPIX = W * H;

   logic clk = 1'b0;
   logic n_rst;
   logic start;
   logic busy;
   logic frame_done;

   always #5 clk = ~clk;

   gray_sequencer_if #(.ADDR_W(AW)) bus();

   gray_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW)) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .start      (start),
      .bus        (bus),
      .busy       (busy),
      .frame_done (frame_done)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // frame-store responder with programmable ack delay
   logic [23:0] mem [NPIX];
   int ack_delay = 0;
   int ack_wait  = 0;
   assign bus.rd_ack  = bus.rd_req && (ack_wait >= ack_delay);
   assign bus.rd_data = mem[bus.rd_addr];
   always @(posedge clk) ack_wait <= (bus.rd_req && !bus.rd_ack) ? ack_wait + 1 : 0;

   // converter model: gray = (R + 4G + B) / 4, saturating
   function automatic logic [7:0] gray1(input logic [23:0] p);
      int s;
      s = (int'(p[23:16]) + 4 * int'(p[15:8]) + int'(p[7:0])) >> 2;
      return (s > 255) ? 8'hFF : s[7:0];
   endfunction

   function automatic logic [31:0] gray4(input logic [3:0][23:0] b);
      return {gray1(b[3]), gray1(b[2]), gray1(b[1]), gray1(b[0])};
   endfunction

   int          conv_lat = 2;
   int          conv_cnt;
   logic [31:0] conv_res;
   logic        spur = 1'b0;

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         conv_cnt       <= 0;
         bus.gray_done  <= 1'b0;
         bus.gray_pixel <= '0;
      end else begin
         bus.gray_done  <= 1'b0;
         bus.gray_pixel <= 32'hDEADBEEF;
         if (bus.gray_en) begin
            conv_cnt <= conv_lat;
            conv_res <= gray4(bus.in_pixel_buffer);
         end else if (conv_cnt == 1) begin
            conv_cnt       <= 0;
            bus.gray_done  <= 1'b1;
            bus.gray_pixel <= conv_res;
         end else if (conv_cnt > 1) begin
            conv_cnt <= conv_cnt - 1;
         end
         if (spur) begin
            bus.gray_done  <= 1'b1;
            bus.gray_pixel <= 32'h0BADF00D;
         end
      end
   end

   // monitor
   logic [31:0]      w_data[$];
   logic             w_eol[$];
   logic             w_eof[$];
   int               addrs[$];
   int               fd_cnt;
   int               gen_cnt;
   int               hold_bad;
   int               ostall_bad;
   logic [3:0][23:0] first_buf;
   logic             rd_pend;
   logic [AW-1:0]    rd_pend_addr;
   logic             o_pend;
   logic [33:0]      o_pend_val;

   initial begin
      rd_pend = 1'b0;
      o_pend  = 1'b0;
      forever begin
         @(posedge clk);
         if (!n_rst) begin
            rd_pend = 1'b0;
            o_pend  = 1'b0;
         end else begin
            if (rd_pend && (!bus.rd_req || bus.rd_addr != rd_pend_addr)) hold_bad++;
            rd_pend      = bus.rd_req && !bus.rd_ack;
            rd_pend_addr = bus.rd_addr;
            if (o_pend && (!bus.out_valid ||
                           {bus.out_data, bus.out_eol, bus.out_eof} != o_pend_val)) ostall_bad++;
            o_pend     = bus.out_valid && !bus.out_ready;
            o_pend_val = {bus.out_data, bus.out_eol, bus.out_eof};
            if (bus.rd_req && bus.rd_ack) addrs.push_back(int'(bus.rd_addr));
            if (bus.out_valid && bus.out_ready) begin
               w_data.push_back(bus.out_data);
               w_eol.push_back(bus.out_eol);
               w_eof.push_back(bus.out_eof);
            end
            if (frame_done) fd_cnt++;
            if (bus.gray_en) begin
               if (gen_cnt == 0) first_buf = bus.in_pixel_buffer;
               gen_cnt++;
            end
         end
      end
   end

   task automatic clear_mon();
      w_data.delete();
      w_eol.delete();
      w_eof.delete();
      addrs.delete();
      fd_cnt     = 0;
      gen_cnt    = 0;
      hold_bad   = 0;
      ostall_bad = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      while (fd_cnt == 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({nm, "_timeout"}, 96'(fd_cnt == 0), 96'(0));
      repeat (3) @(negedge clk);
   endtask

   task automatic check_addrs(input string nm);
      int bad = 0;
      for (int i = 0; i < NPIX; i++) begin
         if (i >= addrs.size() || addrs[i] != i) bad++;
      end
      check({nm, "_addr_cnt"}, 96'(addrs.size()), 96'(NPIX));
      check({nm, "_addr_order"}, 96'(bad), 96'(0));
   endtask

   task automatic check_words_ff(input string nm);
      check({nm, "_words"}, 96'(w_data.size()), 96'(4));
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s_data%0d", nm, i), (i < w_data.size()) ? w_data[i] : 32'hx, 96'h0FFFF_FFFF);
         check($sformatf("%s_eol%0d", nm, i), (i < w_eol.size()) ? w_eol[i] : 1'bx, 96'(i % 2 == 1));
         check($sformatf("%s_eof%0d", nm, i), (i < w_eof.size()) ? w_eof[i] : 1'bx, 96'(i == 3));
      end
   endtask

   task automatic check_idle_outputs(input string nm);
      check({nm, "_rd_req"}, bus.rd_req, 0);
      check({nm, "_gray_en"}, bus.gray_en, 0);
      check({nm, "_out_valid"}, bus.out_valid, 0);
      check({nm, "_eol_eof"}, {bus.out_eol, bus.out_eof}, 0);
      check({nm, "_busy"}, busy, 0);
      check({nm, "_frame_done"}, frame_done, 0);
      check({nm, "_rd_addr"}, bus.rd_addr, 0);
      check({nm, "_buf"}, bus.in_pixel_buffer, 0);
      check({nm, "_out_data"}, bus.out_data, 0);
   endtask

   typedef struct {
      logic [3:0][23:0] px;   // px[3] is fetched first
      logic [31:0]      data;
      logic             eol;
      logic             eof;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int n;
      int bad;
      int rdq;
      logic [33:0] snap;

      vecs[0] = '{{24'h400000, 24'h800000, 24'hC00000, 24'h000000}, 32'h10203000, 1'b0, 1'b0};
      vecs[1] = '{{24'hFCFCFC, 24'hFCFCFC, 24'hFCFCFC, 24'hFCFCFC}, 32'hFFFFFFFF, 1'b1, 1'b0};
      vecs[2] = '{{24'h001000, 24'h002000, 24'h003F00, 24'h000000}, 32'h10203F00, 1'b0, 1'b0};
      vecs[3] = '{{24'h000004, 24'h000008, 24'h0000FF, 24'h000001}, 32'h01023F00, 1'b1, 1'b1};

      n_rst = 1'b0;
      start = 1'b0;
      bus.out_ready = 1'b1;
      clear_mon();
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      n_rst = 1'b1;
      @(negedge clk);

      // table-driven frame
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            mem[4*i + j] = vecs[i].px[3-j];
      clear_mon();
      pulse_start();
      wait_done("tbl");
      check("tbl_words", 96'(w_data.size()), 96'(4));
      for (int i = 0; i < 4; i++) begin
         check($sformatf("tbl_data%0d", i), (i < w_data.size()) ? w_data[i] : 32'hx, vecs[i].data);
         check($sformatf("tbl_eol%0d", i), (i < w_eol.size()) ? w_eol[i] : 1'bx, vecs[i].eol);
         check($sformatf("tbl_eof%0d", i), (i < w_eof.size()) ? w_eof[i] : 1'bx, vecs[i].eof);
      end
      check("tbl_slot3", first_buf[3], 24'h400000);
      check("tbl_slot0", first_buf[0], 24'h000000);
      check("tbl_gray_en_cnt", 96'(gen_cnt), 96'(4));
      check_addrs("tbl");
      check("tbl_frame_done_cnt", 96'(fd_cnt), 96'(1));
      check("tbl_busy_after", busy, 0);
      check("tbl_rd_addr_after", bus.rd_addr, 0);

      // all-saturating frame with 3-cycle read back-pressure
      for (int i = 0; i < NPIX; i++) mem[i] = 24'hFCFCFC;
      ack_delay = 3;
      conv_lat  = 4;
      clear_mon();
      pulse_start();
      wait_done("bp");
      check_words_ff("bp");
      check_addrs("bp");
      check("bp_rd_hold", 96'(hold_bad), 96'(0));
      check("bp_frame_done_cnt", 96'(fd_cnt), 96'(1));

      // output stall on the first word
      ack_delay = 0;
      conv_lat  = 2;
      bus.out_ready = 1'b0;
      clear_mon();
      pulse_start();
      n = 0;
      while (!bus.out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("stall_valid_timeout", 96'(bus.out_valid), 96'(1));
      snap = {bus.out_data, bus.out_eol, bus.out_eof};
      bad = 0;
      rdq = 0;
      repeat (10) begin
         @(negedge clk);
         if (!bus.out_valid || {bus.out_data, bus.out_eol, bus.out_eof} != snap) bad++;
         if (bus.rd_req) rdq++;
      end
      check("stall_stable", 96'(bad), 96'(0));
      check("stall_no_rd_req", 96'(rdq), 96'(0));
      check("stall_no_xfer", 96'(w_data.size()), 96'(0));
      bus.out_ready = 1'b1;
      wait_done("stall");
      check_words_ff("stall");
      check_addrs("stall");
      check("stall_out_hold", 96'(ostall_bad), 96'(0));

      // spurious gray_done and start while fetching
      ack_delay = 3;
      clear_mon();
      pulse_start();
      n = 0;
      while (!(bus.rd_req && bus.rd_addr == AW'(5)) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("spur_reach_timeout", 96'(bus.rd_req && bus.rd_addr == AW'(5)), 96'(1));
      spur  = 1'b1;
      start = 1'b1;
      @(negedge clk);
      spur  = 1'b0;
      start = 1'b0;
      check("spur_still_fetch", bus.rd_req, 1);
      wait_done("spur");
      check_words_ff("spur");
      check_addrs("spur");
      check("spur_frame_done_cnt", 96'(fd_cnt), 96'(1));

      // start coinciding with frame_done is dropped
      ack_delay = 0;
      clear_mon();
      pulse_start();
      n = 0;
      while (!frame_done && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("fdstart_timeout", frame_done, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("fdstart_ignored_busy", busy, 0);
      check("fdstart_ignored_rd", 96'(addrs.size()), 96'(NPIX));

      // reset while waiting on the converter
      conv_lat = 6;
      clear_mon();
      pulse_start();
      n = 0;
      while (!bus.gray_en && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("rst_gray_en_timeout", bus.gray_en, 1);
      @(negedge clk);
      n_rst = 1'b0;
      #1;
      check_idle_outputs("midrst");
      @(negedge clk);
      n_rst = 1'b1;
      conv_lat = 2;
      @(negedge clk);
      for (int i = 0; i < NPIX; i++) mem[i] = 24'hFCFCFC;
      clear_mon();
      pulse_start();
      wait_done("rerun");
      check_words_ff("rerun");
      check_addrs("rerun");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/gray_sequencer.md
Name: gray_sequencer

Overview:
Sequences the grayscale converter for a full frame. Fetches RGB pixels from the frame-store read port and packs them four at a time into the converter's input buffer. Pulses gray_en, captures the packed grayscale result when gray_done is asserted, and streams it downstream over a valid/ready interface with end-of-line and end-of-frame flags. Sits between the frame-store reader and the Sobel line buffers.

Parameters:
IMG_WIDTH, 640, pixels per row; must be a multiple of 4 and at least 4.
IMG_HEIGHT, 480, rows per frame; at least 1.
ADDR_W, 20, read address width; 2^ADDR_W must be at least IMG_WIDTH*IMG_HEIGHT.

Ports:
clk  in  1  system clock, rising edge.
n_rst  in  1  asynchronous active-low reset.
start  in  1  begin a frame; sampled only in IDLE.
rd_req  out  1  pixel read request.
rd_addr  out  ADDR_W  linear pixel index, row*IMG_WIDTH+col.
rd_data  in  24  RGB888 pixel {R[23:16],G[15:8],B[7:0]}; valid in the rd_ack cycle.
rd_ack  in  1  read complete.
in_pixel_buffer  out  4x24  packed pixels to the converter.
gray_en  out  1  one-cycle converter start.
gray_pixel  in  4x8  converter result; valid only while gray_done=1.
gray_done  in  1  converter result strobe.
out_valid  out  1  packed gray word available.
out_ready  in  1  downstream accepts.
out_data  out  32  four gray pixels; [31:24] is the leftmost pixel.
out_eol  out  1  word is the last of a row; qualified by out_valid.
out_eof  out  1  word is the last of the frame; qualified by out_valid.
busy  out  1  high in every state except IDLE.
frame_done  out  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset: state=IDLE. rd_req, gray_en, out_valid, out_eol, out_eof, busy and frame_done are 0. rd_addr=0, in_pixel_buffer=0, out_data=0. The pixel index and slot counter are cleared. Reset mid-frame aborts immediately; no partial word is emitted.
- States: IDLE, FETCH, GRAY_GO, GRAY_WAIT, EMIT, DONE.
- IDLE: start=1 -> FETCH. The pixel index and slot counter k are cleared to 0.
- FETCH:
  - rd_req=1, with rd_addr held at the current index until rd_ack is sampled.
  - rd_ack may arrive in the same cycle rd_req rises.
  - On ack, rd_data is written to in_pixel_buffer[3-k], so the first pixel goes to slot [3]. The index then increments and k increments.
  - After the 4th ack (k=3) -> GRAY_GO. rd_req drops in that cycle.
- GRAY_GO: gray_en=1 for exactly one cycle -> GRAY_WAIT. in_pixel_buffer holds stable from this cycle until the next FETCH.
- GRAY_WAIT:
  - Wait with no timeout.
  - In the cycle gray_done=1, capture gray_pixel into out_data, since the result is valid only in that cycle.
  - Compute out_eol = (index mod IMG_WIDTH == 0) and out_eof = (index == IMG_WIDTH*IMG_HEIGHT), using the index after the 4th fetch.
  - Then -> EMIT.
- gray_done outside GRAY_WAIT is ignored.
- EMIT:
  - out_valid=1, with out_data, out_eol and out_eof stable until out_ready is sampled.
  - If out_ready is already high when out_valid rises, the transfer completes that cycle.
  - On transfer: if out_eof=1 -> DONE, else k=0 -> FETCH.
  - out_valid drops the cycle after the transfer.
- DONE: frame_done=1 for one cycle -> IDLE. The index is cleared.
- start while busy is ignored. A start pulse asserted in the same cycle as frame_done is also ignored; start must be reasserted in IDLE.
- Throughput floor per word: 4 fetch cycles (ack same cycle) + 1 GRAY_GO + converter latency + 1 EMIT.
- rd_addr never exceeds IMG_WIDTH*IMG_HEIGHT-1. No read is issued after the last pixel.

Test Plan:
- IMG_WIDTH=8, IMG_HEIGHT=2, memory returning pixel i = {8'hFC,8'hFC,8'hFC}, acks same cycle, out_ready tied 1, start pulse -> 4 words, each 0xFFFFFFFF (converter saturates). out_eol on words 2 and 4, out_eof only on word 4, frame_done a single pulse, rd_addr 0..15 in order.
- Slot ordering: pixels 0..3 = R 0x40, 0x80, 0xC0, 0x00, G=B=0 -> in_pixel_buffer[3].R=0x40 and [0].R=0x00 at gray_en. out_data=0x10203000.
- Read back-pressure: rd_ack delayed 3 cycles per request -> rd_req and rd_addr held stable through each wait. No duplicate or skipped addresses.
- Output stall: out_ready low for 10 cycles during EMIT -> out_data, out_eol and out_eof stable. No new rd_req until the transfer; the frame still completes with 4 words.
- Spurious inputs: gray_done pulsed during FETCH and start pulsed mid-frame -> no state change, no extra word, no frame restart.
- Reset mid-operation: n_rst low during GRAY_WAIT -> all outputs 0 immediately. A new start after release begins again at rd_addr=0.
